pipelined_cla_adder: RTL



---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_group.sv | 34 +++
 rtl/pipelined_cla_adder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and helpers for the pipelined carry-lookahead adder
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef logic [GROUP_W-1:0] group_t;

    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

    // Per-stage control: beat-present bit and the carry out of the previous group.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - 4-bit carry-lookahead slice with group propagate/generate
module cla_group
    import cla_pkg::*;
(
    input  group_t a_i,
    input  group_t b_i,
    input  logic   cin_i,
    output group_t s_o,
    output logic   cout_o,
    output logic   pg_o,
    output logic   gg_o,
    output logic   c3_o
);

    group_t g;
    group_t p;
    logic   c1;
    logic   c2;
    logic   c3;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c1 = g[0] | (p[0] & cin_i);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

    assign gg_o   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg_o   = &p;
    assign cout_o = gg_o | (pg_o & cin_i);
    assign c3_o   = c3;
    assign s_o    = p ^ {c3, c2, c1, cin_i};

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined CLA add/sub, one 4-bit group per stage
// Optional ovf/zero status outputs are built when CLA_FLAGS_EN is defined.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef CLA_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NG = num_groups(WIDTH);

    stage_ctl_t       ctl_q  [NG];
    logic [WIDTH-1:0] a_q    [NG];
    logic [WIDTH-1:0] b_q    [NG];
    logic [WIDTH-1:0] s_q    [NG];
    logic [WIDTH-1:0] s_next [NG];

    group_t           grp_s  [NG];
    logic [NG-1:0]    grp_co;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_c3;

    logic             out_valid_q;
    logic [WIDTH-1:0] s_out_q;
    logic             c_out_q;
    logic             advance;
    logic             unused_ok;

    assign advance  = out_ready | ~out_valid_q;
    assign in_ready = advance;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group u_grp (
            .a_i    (a_q[k][k*GROUP_W +: GROUP_W]),
            .b_i    (b_q[k][k*GROUP_W +: GROUP_W]),
            .cin_i  (ctl_q[k].carry),
            .s_o    (grp_s[k]),
            .cout_o (grp_co[k]),
            .pg_o   (grp_p[k]),
            .gg_o   (grp_g[k]),
            .c3_o   (grp_c3[k])
        );
    end

    // Stage k's sum word with its own group's bits filled in.
    always_comb begin
        for (int k = 0; k < NG; k++) begin
            s_next[k] = s_q[k];
            s_next[k][k*GROUP_W +: GROUP_W] = grp_s[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NG; k++) begin
                ctl_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end
            out_valid_q <= 1'b0;
            s_out_q     <= '0;
            c_out_q     <= 1'b0;
        end else if (advance) begin
            ctl_q[0].valid <= in_valid;
            ctl_q[0].carry <= sub | c_in;
            a_q[0]         <= a;
            b_q[0]         <= sub ? ~b : b;
            s_q[0]         <= '0;
            for (int k = 1; k < NG; k++) begin
                ctl_q[k].valid <= ctl_q[k-1].valid;
                ctl_q[k].carry <= grp_co[k-1];
                a_q[k]         <= a_q[k-1];
                b_q[k]         <= b_q[k-1];
                s_q[k]         <= s_next[k-1];
            end
            out_valid_q <= ctl_q[NG-1].valid;
            s_out_q     <= s_next[NG-1];
            c_out_q     <= grp_co[NG-1];
        end
    end

`ifdef CLA_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= grp_c3[NG-1] ^ grp_co[NG-1];
            zero_q <= ~|s_next[NG-1];
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

    assign out_valid = out_valid_q;
    assign s         = s_out_q;
    assign c_out     = c_out_q;

    // Group P/G feed a future block-level lookahead; last-stage operands are fully consumed.
    assign unused_ok = ^{grp_p, grp_g, grp_c3, a_q[NG-1], b_q[NG-1], s_q[0]};

endmodule
